// File: rtl/qspi_resp_pkg.sv
// rtl/qspi_resp_pkg.sv - shared types and constants for the QSPI memory responder
package qspi_resp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_RDATA,
        S_WDATA,
        S_IGNORE
    } state_e;

    localparam int CMD_NIB = 2;
    localparam int ADR_NIB = 6;

    localparam logic [7:0] DEF_CMD_RD = 8'hEB;
    localparam logic [7:0] DEF_CMD_WR = 8'h38;

    function automatic logic [23:0] shift_nib(input logic [23:0] v, input logic [3:0] n);
        return {v[19:0], n};
    endfunction

endpackage

// File: rtl/qspi_resp_sync.sv
// rtl/qspi_resp_sync.sv - input synchronizers and edge pulses for cs_n and sck
module qspi_resp_sync (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cs_n_i,
    input  logic       sck_i,
    input  logic [3:0] sd_i,
    output logic [3:0] sd_o,
    output logic       sck_rise_o,
    output logic       sck_fall_o,
    output logic       cs_rise_o,
    output logic       cs_fall_o
);

    logic       cs_meta_q, cs_sync_q, cs_dly_q;
    logic       sck_meta_q, sck_sync_q, sck_dly_q;
    logic [3:0] sd_meta_q, sd_sync_q;

    // sd shares the sck pipeline depth so data is aligned with the detected edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cs_meta_q  <= 1'b1;
            cs_sync_q  <= 1'b1;
            cs_dly_q   <= 1'b1;
            sck_meta_q <= 1'b0;
            sck_sync_q <= 1'b0;
            sck_dly_q  <= 1'b0;
            sd_meta_q  <= 4'h0;
            sd_sync_q  <= 4'h0;
        end else begin
            cs_meta_q  <= cs_n_i;
            cs_sync_q  <= cs_meta_q;
            cs_dly_q   <= cs_sync_q;
            sck_meta_q <= sck_i;
            sck_sync_q <= sck_meta_q;
            sck_dly_q  <= sck_sync_q;
            sd_meta_q  <= sd_i;
            sd_sync_q  <= sd_meta_q;
        end
    end

    assign sd_o       = sd_sync_q;
    assign sck_rise_o = sck_sync_q & ~sck_dly_q;
    assign sck_fall_o = ~sck_sync_q & sck_dly_q;
    assign cs_rise_o  = cs_sync_q & ~cs_dly_q;
    assign cs_fall_o  = ~cs_sync_q & cs_dly_q;

endmodule

// File: rtl/qspi_mem_responder.sv
// rtl/qspi_mem_responder.sv - quad-SPI device responder mapped onto a byte-wide memory port
module qspi_mem_responder
    import qspi_resp_pkg::*;
#(
    parameter int         ADRW   = 16,
    parameter int         DUMMY  = 6,
    parameter logic [7:0] CMD_RD = DEF_CMD_RD,
    parameter logic [7:0] CMD_WR = DEF_CMD_WR
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            qspi_cs_in,
    input  logic            qspi_sck_i,
    input  logic [3:0]      qspi_sd_i,
    output logic [3:0]      qspi_sd_o,
    output logic [3:0]      qspi_sd_oen_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [ADRW-1:0] mem_adr_o,
    output logic [7:0]      mem_wdat_o,
    input  logic [7:0]      mem_rdat_i,
    input  logic            mem_ack_i,
    output logic            busy_o,
    output logic            cmd_err_o
);

    localparam logic [7:0] CMD_LAST = 8'(CMD_NIB - 1);
    localparam logic [7:0] ADR_LAST = 8'(ADR_NIB - 1);
    localparam logic [7:0] DUM_CNT  = 8'(DUMMY);

    logic [3:0] sd_s;
    logic       sck_rise, sck_fall, cs_rise, cs_fall;
    logic       rise, fall, req_free;
    logic [7:0] wbyte;
    logic [ADRW-1:0] adr_inc;

    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [23:0]     shift_q, shift_d;
    logic            rd_q, rd_d, phase_q, phase_d;
    logic [3:0]      whi_q, whi_d, sd_q, sd_d;
    logic            oen_q, oen_d, err_q, err_d;
    logic [ADRW-1:0] adr_q, adr_d, madr_q, madr_d, pend_adr_q, pend_adr_d;
    logic [7:0]      cur_q, cur_d, nxt_q, nxt_d, wdat_q, wdat_d, pend_dat_q, pend_dat_d;
    logic            req_q, req_d, we_q, we_d, pend_q, pend_d;

    qspi_resp_sync u_sync (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cs_n_i     (qspi_cs_in),
        .sck_i      (qspi_sck_i),
        .sd_i       (qspi_sd_i),
        .sd_o       (sd_s),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall),
        .cs_rise_o  (cs_rise),
        .cs_fall_o  (cs_fall)
    );

    // cs deassertion masks any sck edge detected in the same cycle
    assign rise     = sck_rise & ~cs_rise;
    assign fall     = sck_fall & ~cs_rise;
    assign req_free = ~req_q & ~pend_q;
    assign adr_inc  = adr_q + ADRW'(1);
    assign wbyte    = {whi_q, sd_s};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rd_d       = rd_q;
        phase_d    = phase_q;
        whi_d      = whi_q;
        sd_d       = sd_q;
        oen_d      = oen_q;
        err_d      = 1'b0;
        adr_d      = adr_q;
        cur_d      = cur_q;
        nxt_d      = nxt_q;
        req_d      = req_q;
        we_d       = we_q;
        madr_d     = madr_q;
        wdat_d     = wdat_q;
        pend_d     = pend_q;
        pend_adr_d = pend_adr_q;
        pend_dat_d = pend_dat_q;

        if (req_q && mem_ack_i) begin
            req_d = 1'b0;
            if (!we_q && (state_q == S_DUMMY || state_q == S_RDATA)) begin
                nxt_d = mem_rdat_i;
            end
        end
        if (!req_q && pend_q) begin
            req_d  = 1'b1;
            we_d   = 1'b1;
            madr_d = pend_adr_q;
            wdat_d = pend_dat_q;
            pend_d = 1'b0;
        end

        if (cs_rise) begin
            state_d = S_IDLE;
            oen_d   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cs_fall) begin
                        state_d = S_CMD;
                        cnt_d   = 8'd0;
                        phase_d = 1'b0;
                    end
                end
                S_CMD: begin
                    if (rise) begin
                        shift_d = shift_nib(shift_q, sd_s);
                        cnt_d   = cnt_q + 8'd1;
                        if (cnt_q == CMD_LAST) begin
                            cnt_d = 8'd0;
                            if (shift_d[7:0] == CMD_RD) begin
                                rd_d    = 1'b1;
                                state_d = S_ADDR;
                            end else if (shift_d[7:0] == CMD_WR) begin
                                rd_d    = 1'b0;
                                state_d = S_ADDR;
                            end else begin
                                err_d   = 1'b1;
                                state_d = S_IGNORE;
                            end
                        end
                    end
                end
                S_ADDR: begin
                    if (rise) begin
                        shift_d = shift_nib(shift_q, sd_s);
                        cnt_d   = cnt_q + 8'd1;
                        if (cnt_q == ADR_LAST) begin
                            cnt_d   = 8'd0;
                            adr_d   = shift_d[ADRW-1:0];
                            phase_d = 1'b0;
                            if (rd_q) begin
                                state_d = S_DUMMY;
                                if (req_free) begin
                                    req_d  = 1'b1;
                                    we_d   = 1'b0;
                                    madr_d = shift_d[ADRW-1:0];
                                end
                            end else begin
                                state_d = S_WDATA;
                            end
                        end
                    end
                end
                // Each high-nibble fall moves the buffered byte out and refills the
                // buffer straight away, giving memory two SCK periods to answer.
                S_DUMMY, S_RDATA: begin
                    if (state_q == S_DUMMY && rise) begin
                        cnt_d = cnt_q + 8'd1;
                    end else if (fall && (state_q == S_RDATA || cnt_q == DUM_CNT)) begin
                        state_d = S_RDATA;
                        oen_d   = 1'b0;
                        if (state_q == S_RDATA && phase_q) begin
                            sd_d    = cur_q[3:0];
                            adr_d   = adr_inc;
                            phase_d = 1'b0;
                        end else begin
                            sd_d    = nxt_q[7:4];
                            cur_d   = nxt_q;
                            phase_d = 1'b1;
                            if (req_free) begin
                                req_d  = 1'b1;
                                we_d   = 1'b0;
                                madr_d = adr_inc;
                            end
                        end
                    end
                end
                S_WDATA: begin
                    if (rise) begin
                        if (!phase_q) begin
                            whi_d   = sd_s;
                            phase_d = 1'b1;
                        end else begin
                            phase_d = 1'b0;
                            adr_d   = adr_inc;
                            if (!req_q && !pend_q) begin
                                req_d  = 1'b1;
                                we_d   = 1'b1;
                                madr_d = adr_q;
                                wdat_d = wbyte;
                            end else begin
                                pend_d     = 1'b1;
                                pend_adr_d = adr_q;
                                pend_dat_d = wbyte;
                            end
                        end
                    end
                end
                S_IGNORE: ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            shift_q    <= 24'd0;
            rd_q       <= 1'b0;
            phase_q    <= 1'b0;
            whi_q      <= 4'h0;
            sd_q       <= 4'h0;
            oen_q      <= 1'b1;
            err_q      <= 1'b0;
            adr_q      <= '0;
            cur_q      <= 8'h00;
            nxt_q      <= 8'h00;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            madr_q     <= '0;
            wdat_q     <= 8'h00;
            pend_q     <= 1'b0;
            pend_adr_q <= '0;
            pend_dat_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rd_q       <= rd_d;
            phase_q    <= phase_d;
            whi_q      <= whi_d;
            sd_q       <= sd_d;
            oen_q      <= oen_d;
            err_q      <= err_d;
            adr_q      <= adr_d;
            cur_q      <= cur_d;
            nxt_q      <= nxt_d;
            req_q      <= req_d;
            we_q       <= we_d;
            madr_q     <= madr_d;
            wdat_q     <= wdat_d;
            pend_q     <= pend_d;
            pend_adr_q <= pend_adr_d;
            pend_dat_q <= pend_dat_d;
        end
    end

    assign qspi_sd_o     = sd_q;
    assign qspi_sd_oen_o = {4{oen_q}};
    assign mem_req_o     = req_q;
    assign mem_we_o      = we_q;
    assign mem_adr_o     = madr_q;
    assign mem_wdat_o    = wdat_q;
    assign busy_o        = (state_q != S_IDLE);
    assign cmd_err_o     = err_q;

endmodule

// File: tb/tb_qspi_mem_responder.sv
// tb/tb_qspi_mem_responder.sv - directed vector bench for qspi_mem_responder
module tb_qspi_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cs_n = 1'b1;
    logic        sck = 1'b0;
    logic [3:0]  sd = 4'h0;
    logic [3:0]  sd_o, sd_oen;
    logic        mem_req, mem_we, mem_ack, busy, cmd_err;
    logic [15:0] mem_adr;
    logic [7:0]  mem_wdat, mem_rdat;

    int tests = 0;
    int fails = 0;

    bit [7:0]    mem [65536];
    logic [15:0] wlog_adr [64];
    logic [7:0]  wlog_dat [64];
    int          wcnt = 0;
    int          reqcnt = 0;
    int          errcnt = 0;
    int          oenlow = 0;

    typedef struct {
        int          kind;   // 0 write, 1 read, 2 unknown opcode
        logic [7:0]  op;
        logic [23:0] addr;
        logic [7:0]  d0, d1;
        logic [15:0] ea0, ea1;
        logic [15:0] enib;
    } vec_t;

    vec_t vecs [7];

    qspi_mem_responder dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .qspi_cs_in    (cs_n),
        .qspi_sck_i    (sck),
        .qspi_sd_i     (sd),
        .qspi_sd_o     (sd_o),
        .qspi_sd_oen_o (sd_oen),
        .mem_req_o     (mem_req),
        .mem_we_o      (mem_we),
        .mem_adr_o     (mem_adr),
        .mem_wdat_o    (mem_wdat),
        .mem_rdat_i    (mem_rdat),
        .mem_ack_i     (mem_ack),
        .busy_o        (busy),
        .cmd_err_o     (cmd_err)
    );

    always #5 clk = ~clk;

    initial begin
        mem_ack  = 1'b0;
        mem_rdat = 8'h00;
    end

    // memory model: ack one cycle after a request is seen
    always @(posedge clk) begin
        if (mem_req && !mem_ack) begin
            mem_ack  <= 1'b1;
            mem_rdat <= mem[mem_adr];
            reqcnt   <= reqcnt + 1;
            if (mem_we) begin
                mem[mem_adr]             <= mem_wdat;
                wlog_adr[wcnt[5:0]]      <= mem_adr;
                wlog_dat[wcnt[5:0]]      <= mem_wdat;
                wcnt                     <= wcnt + 1;
            end
        end else begin
            mem_ack <= 1'b0;
        end
        if (cmd_err) errcnt <= errcnt + 1;
        if (sd_oen != 4'hF) oenlow <= oenlow + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic nib(input logic [3:0] v, output logic [3:0] s, output logic [3:0] oe);
        sd = v;
        #40 sck = 1'b1;
        #39 s = sd_o;
        oe = sd_oen;
        #1 sck = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int r0, e0, o0, w0;
        logic [3:0] s, oe;
        logic [7:0] dat [2];
        r0 = reqcnt; e0 = errcnt; o0 = oenlow; w0 = wcnt;
        dat[0] = v.d0; dat[1] = v.d1;
        cs_n = 1'b0;
        #80;
        chk("busy_in_frame", 32'(busy), 32'd1);
        nib(v.op[7:4], s, oe);
        nib(v.op[3:0], s, oe);
        for (int i = 0; i < 6; i++) nib(v.addr[23-4*i -: 4], s, oe);
        if (v.kind == 0) begin
            for (int i = 0; i < 2; i++) begin
                nib(dat[i][7:4], s, oe);
                nib(dat[i][3:0], s, oe);
            end
        end else if (v.kind == 1) begin
            for (int i = 0; i < 6; i++) nib(4'h0, s, oe);
            chk("oen_before_data", 32'(oe), 32'hF);
            for (int i = 0; i < 4; i++) begin
                nib(4'h0, s, oe);
                chk("rd_nibble", 32'(s), 32'(v.enib[15-4*i -: 4]));
                chk("rd_oen_low", 32'(oe), 32'h0);
            end
        end else begin
            for (int i = 0; i < 6; i++) nib(4'h0, s, oe);
        end
        #40 cs_n = 1'b1;
        #200;
        chk("busy_after_cs", 32'(busy), 32'd0);
        chk("oen_after_cs", 32'(sd_oen), 32'hF);
        if (v.kind == 0) begin
            chk("wr_count", 32'(wcnt - w0), 32'd2);
            chk("wr0_adr", 32'(wlog_adr[w0[5:0]]), 32'(v.ea0));
            chk("wr0_dat", 32'(wlog_dat[w0[5:0]]), 32'(v.d0));
            chk("wr1_adr", 32'(wlog_adr[6'(w0 + 1)]), 32'(v.ea1));
            chk("wr1_dat", 32'(wlog_dat[6'(w0 + 1)]), 32'(v.d1));
        end else if (v.kind == 2) begin
            chk("err_pulses", 32'(errcnt - e0), 32'd1);
            chk("err_no_req", 32'(reqcnt - r0), 32'd0);
            chk("err_oen_high", 32'(oenlow - o0), 32'd0);
        end else begin
            chk("rd_no_err", 32'(errcnt - e0), 32'd0);
        end
    endtask

    initial begin
        logic [3:0] s, oe;
        int r0;
        vecs[0] = '{0, 8'h38, 24'h000010, 8'hA5, 8'h3C, 16'h0010, 16'h0011, 16'h0000};
        vecs[1] = '{1, 8'hEB, 24'h000010, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'hA53C};
        vecs[2] = '{0, 8'h38, 24'h00FFFF, 8'h11, 8'h22, 16'hFFFF, 16'h0000, 16'h0000};
        vecs[3] = '{1, 8'hEB, 24'h00FFFF, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h1122};
        vecs[4] = '{0, 8'h38, 24'h123456, 8'h5A, 8'hC3, 16'h3456, 16'h3457, 16'h0000};
        vecs[5] = '{1, 8'hEB, 24'hAB3456, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h5AC3};
        vecs[6] = '{2, 8'h9F, 24'h000010, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000};

        #1 rst = 1'b1;
        #21;
        chk("rst_sd_o", 32'(sd_o), 32'h0);
        chk("rst_oen", 32'(sd_oen), 32'hF);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_adr", 32'(mem_adr), 32'h0);
        chk("rst_wdat", 32'(mem_wdat), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(cmd_err), 32'h0);
        rst = 1'b0;
        #100;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // aborted write: a lone nibble must never reach memory
        r0 = reqcnt;
        cs_n = 1'b0;
        #80;
        nib(4'h3, s, oe);
        nib(4'h8, s, oe);
        for (int i = 0; i < 6; i++) nib((i == 4) ? 4'h2 : 4'h0, s, oe);
        nib(4'h7, s, oe);
        #40 cs_n = 1'b1;
        #200;
        chk("abort_no_req", 32'(reqcnt - r0), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        run_vec(vecs[1]);

        // reset in the middle of read data
        cs_n = 1'b0;
        #80;
        nib(4'hE, s, oe);
        nib(4'hB, s, oe);
        for (int i = 0; i < 6; i++) nib((i == 4) ? 4'h1 : 4'h0, s, oe);
        for (int i = 0; i < 6; i++) nib(4'h0, s, oe);
        nib(4'h0, s, oe);
        chk("mid_rd_nibble", 32'(s), 32'hA);
        chk("mid_rd_oen", 32'(oe), 32'h0);
        #5 rst = 1'b1;
        #1;
        chk("async_rst_oen", 32'(sd_oen), 32'hF);
        chk("async_rst_req", 32'(mem_req), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        #4 cs_n = 1'b1;
        #100 rst = 1'b0;
        #200;
        run_vec(vecs[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
